// File: rtl/btb_pkg.sv
// ============================================================================
// Module      : btb_pkg
// Description : Shared types and constants for the BTB update controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btb_pkg;

    localparam int ENTRY_W = 60;
    localparam int IDX_W   = 5;
    localparam int TAG_W   = 25;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
    } btb_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } btb_upd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } drain_state_t;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'd3) res = ctr + 2'd1;
        end else begin
            if (ctr != 2'd0) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btb_upd_fifo.sv
// ============================================================================
// Module      : btb_upd_fifo
// Description : Synchronous FIFO holding resolved-branch updates awaiting drain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  btb_upd_t push_data,
    input  logic     pop,
    output btb_upd_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    btb_upd_t         r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign full   = (r_count == (PTR_W+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign head   = r_mem[r_rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/btb_ctrl.sv
// ============================================================================
// Module      : btb_ctrl
// Description : BTB lookup plus queued read-modify-write update controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_ctrl
    import btb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_valid,
    input  logic [31:0]        fetch_pc,
    output logic               pred_hit,
    output logic               pred_taken,
    output logic [31:0]        pred_target,
    input  logic               upd_valid,
    input  logic [31:0]        upd_pc,
    input  logic               upd_taken,
    input  logic [31:0]        upd_target,
    output logic               upd_ready,
    output logic               arr_write,
    output logic [IDX_W-1:0]   arr_index,
    output logic [ENTRY_W-1:0] arr_datain,
    input  logic [ENTRY_W-1:0] arr_dataout
);

    drain_state_t r_state;
    drain_state_t w_next;
    btb_entry_t   r_latch;
    btb_entry_t   w_rd_entry;
    btb_entry_t   w_new_entry;
    btb_upd_t     w_head;
    btb_upd_t     w_push_data;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_lat_hit;
    logic         w_do_write;
    logic         w_unused;

    assign w_rd_entry = btb_entry_t'(arr_dataout);
    assign w_unused   = ^{fetch_pc[1:0], w_head.pc[1:0], w_empty};

    // Lookup path is purely combinational off the array read port.
    assign pred_hit    = fetch_valid & w_rd_entry.valid & (w_rd_entry.tag == fetch_pc[31:7]);
    assign pred_taken  = pred_hit & w_rd_entry.ctr[1];
    assign pred_target = pred_hit ? w_rd_entry.target : 32'd0;

    assign w_push_data = '{pc: upd_pc, taken: upd_taken, target: upd_target};
    assign upd_ready   = ~w_full;

    btb_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (upd_valid),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_latch <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_RD && !fetch_valid) r_latch <= w_rd_entry;
        end
    end

    // Only this controller writes the array, so the latched entry stays
    // coherent even if WR is stalled by fetches for many cycles.
    assign w_lat_hit = r_latch.valid & (r_latch.tag == w_head.pc[31:7]);

    always_comb begin
        w_new_entry = r_latch;
        w_do_write  = 1'b0;
        if (w_lat_hit) begin
            w_new_entry.ctr = ctr_step(r_latch.ctr, w_head.taken);
            if (w_head.taken) w_new_entry.target = w_head.target;
            w_do_write = 1'b1;
        end else if (w_head.taken) begin
            w_new_entry.valid  = 1'b1;
            w_new_entry.tag    = w_head.pc[31:7];
            w_new_entry.target = w_head.target;
            w_new_entry.ctr    = 2'b10;
            w_do_write         = 1'b1;
        end
    end

    assign arr_datain = w_new_entry;

    always_comb begin
        w_next    = r_state;
        arr_write = 1'b0;
        w_pop     = 1'b0;
        arr_index = fetch_valid ? fetch_pc[6:2] : w_head.pc[6:2];
        if (!fetch_valid) begin
            case (r_state)
                ST_IDLE: if (!w_full && w_empty) w_next = ST_IDLE;
                         else                    w_next = ST_RD;
                ST_RD:   w_next = ST_WR;
                ST_WR: begin
                    arr_write = w_do_write;
                    w_pop     = 1'b1;
                    w_next    = ST_IDLE;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_btb_ctrl.sv
// ============================================================================
// Module      : tb_btb_ctrl
// Description : Directed scoreboard bench for btb_ctrl with a BTB array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btb_ctrl;
    import btb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_ready;
    logic        arr_write;
    logic [4:0]  arr_index;
    logic [59:0] arr_datain;
    logic [59:0] arr_dataout;

    logic [59:0] mem [32] = '{default: '0};

    typedef struct { logic [4:0] idx; logic [59:0] data; } wr_t;
    typedef struct { logic hit; logic taken; logic [31:0] tgt; } pr_t;
    wr_t exp_wr[$];
    pr_t exp_pr[$];
    wr_t mon_w;
    pr_t mon_p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btb_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_ready   (upd_ready),
        .arr_write   (arr_write),
        .arr_index   (arr_index),
        .arr_datain  (arr_datain),
        .arr_dataout (arr_dataout)
    );

    // Array model: combinational read, synchronous write.
    assign arr_dataout = mem[arr_index];
    always @(posedge clk) if (rst_n && arr_write) mem[arr_index] <= arr_datain;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [59:0] ent(input logic [24:0] tag, input logic [31:0] tgt,
                                        input logic [1:0] ctr);
        return {1'b1, tag, tgt, ctr};
    endfunction

    // Monitor: compares array writes and lookups against queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (arr_write) begin
                chk("write_during_fetch", {63'd0, fetch_valid}, 64'd0);
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: actual idx %0d data %0h required no write",
                             arr_index, arr_datain);
                end else begin
                    mon_w = exp_wr.pop_front();
                    chk("wr_idx", {59'd0, arr_index}, {59'd0, mon_w.idx});
                    chk("wr_data", {4'd0, arr_datain}, {4'd0, mon_w.data});
                end
            end
            if (fetch_valid && exp_pr.size() > 0) begin
                mon_p = exp_pr.pop_front();
                chk("pred_hit", {63'd0, pred_hit}, {63'd0, mon_p.hit});
                chk("pred_taken", {63'd0, pred_taken}, {63'd0, mon_p.taken});
                chk("pred_target", {32'd0, pred_target}, {32'd0, mon_p.tgt});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                       input logic ready_req);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = t;
        upd_target = tg;
        #1;
        chk("upd_ready", {63'd0, upd_ready}, {63'd0, ready_req});
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic exp_write(input logic [4:0] idx, input logic [59:0] data);
        wr_t w;
        w.idx  = idx;
        w.data = data;
        exp_wr.push_back(w);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic h, input logic t,
                         input logic [31:0] tg);
        pr_t p;
        p.hit   = h;
        p.taken = t;
        p.tgt   = tg;
        exp_pr.push_back(p);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        tick();
        fetch_valid = 1'b0;
        fetch_pc    = 32'd0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_wr.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_done", {63'd0, (n < 100)}, 64'd1);
        repeat (6) tick();
    endtask

    initial begin
        bit seen;
        rst_n       = 1'b0;
        fetch_valid = 1'b0;
        fetch_pc    = 32'd0;
        upd_valid   = 1'b0;
        upd_pc      = 32'd0;
        upd_taken   = 1'b0;
        upd_target  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_upd_ready", {63'd0, upd_ready}, 64'd1);
        chk("rst_arr_write", {63'd0, arr_write}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Empty BTB lookup.
        fetch(32'h100, 1'b0, 1'b0, 32'h0);

        // Miss/taken allocates with ctr=2.
        exp_write(5'd0, ent(25'd2, 32'h200, 2'd2));
        upd(32'h100, 1'b1, 32'h200, 1'b1);
        wait_drain();
        fetch(32'h100, 1'b1, 1'b1, 32'h200);

        // Not-taken decrements, target kept, saturates at 0.
        exp_write(5'd0, ent(25'd2, 32'h200, 2'd1));
        exp_write(5'd0, ent(25'd2, 32'h200, 2'd0));
        upd(32'h100, 1'b0, 32'hDEAD0000, 1'b1);
        upd(32'h100, 1'b0, 32'hDEAD0000, 1'b1);
        wait_drain();
        fetch(32'h100, 1'b1, 1'b0, 32'h200);
        exp_write(5'd0, ent(25'd2, 32'h200, 2'd0));
        upd(32'h100, 1'b0, 32'hBEEF0000, 1'b1);
        wait_drain();

        // Alias at index 0 replaces the entry.
        exp_write(5'd0, ent(25'h22, 32'h300, 2'd2));
        upd(32'h1100, 1'b1, 32'h300, 1'b1);
        wait_drain();
        fetch(32'h100, 1'b0, 1'b0, 32'h0);
        fetch(32'h1100, 1'b1, 1'b1, 32'h300);

        // Miss/not-taken writes nothing; hit/taken saturates at 3 with new target.
        upd(32'h180, 1'b0, 32'h999, 1'b1);
        exp_write(5'd0, ent(25'h22, 32'h400, 2'd3));
        exp_write(5'd0, ent(25'h22, 32'h500, 2'd3));
        upd(32'h1100, 1'b1, 32'h400, 1'b1);
        upd(32'h1100, 1'b1, 32'h500, 1'b1);
        wait_drain();
        fetch(32'h1100, 1'b1, 1'b1, 32'h500);

        // Fill the queue under a continuous fetch stall.
        fetch_valid = 1'b1;
        fetch_pc    = 32'hF00;
        for (int i = 1; i <= 4; i++) begin
            exp_write(5'(i), ent(25'd2, 32'h1000 + 32'(i), 2'd2));
            upd(32'h100 + 32'(4 * i), 1'b1, 32'h1000 + 32'(i), 1'b1);
        end
        chk("full_ready_low", {63'd0, upd_ready}, 64'd0);
        upd(32'h114, 1'b1, 32'h2000, 1'b0);
        repeat (3) tick();
        fetch_valid = 1'b0;
        fetch_pc    = 32'd0;
        wait_drain();
        chk("ready_after_drain", {63'd0, upd_ready}, 64'd1);

        // Reset asserted while the write is being presented.
        exp_write(5'd0, ent(25'd4, 32'h600, 2'd2));
        upd(32'h200, 1'b1, 32'h600, 1'b1);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            if (arr_write) seen = 1'b1;
            else tick();
        end
        chk("wr_reached", {63'd0, seen}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_write", {63'd0, arr_write}, 64'd0);
        chk("rst_mid_ready", {63'd0, upd_ready}, 64'd1);
        exp_wr.delete();
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("array_kept", {4'd0, mem[0]}, {4'd0, ent(25'h22, 32'h500, 2'd3)});
        fetch(32'h200, 1'b0, 1'b0, 32'h0);
        fetch(32'h1100, 1'b1, 1'b1, 32'h500);
        repeat (2) tick();

        chk("exp_pr_empty", 64'(exp_pr.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual timeout required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
